// File: rtl/nn_argmax_collector_if.sv
// nn_argmax_collector_if: activation capture and result handshake bundle for the argmax collector
interface nn_argmax_collector_if #(
    parameter int DataWidth  = 8,
    parameter int NumOutputs = 4,
    parameter int IdxWidth   = (NumOutputs > 1) ? $clog2(NumOutputs) : 1
) ();
    logic [DataWidth*NumOutputs-1:0] actv_i;
    logic [NumOutputs-1:0]           req_i;
    logic [NumOutputs-1:0]           ack_o;
    logic                            valid_o;
    logic                            ready_i;
    logic [IdxWidth-1:0]             class_o;
    logic [DataWidth-1:0]            max_o;
    modport slave  (input actv_i, req_i, ready_i, output ack_o, valid_o, class_o, max_o);
    modport master (output actv_i, req_i, ready_i, input ack_o, valid_o, class_o, max_o);
endinterface

// File: rtl/nn_argmax_collector.sv
// nn_argmax_collector: buffers one activation per output neuron, runs a sequential signed argmax, presents the winner
module nn_argmax_collector #(
    parameter int DataWidth  = 8,
    parameter int NumOutputs = 4,
    parameter int IdxWidth   = (NumOutputs > 1) ? $clog2(NumOutputs) : 1,
    parameter int CountWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    nn_argmax_collector_if.slave  bus,
    output logic                  busy_o,
    output logic [CountWidth-1:0] done_count_o
);
    localparam logic [1:0] COLLECT = 2'd0, SCAN = 2'd1, PRESENT = 2'd2;
    logic [1:0]                  state_q, state_d;
    logic [NumOutputs-1:0]       full_q, ack_q, cap;
    logic signed [DataWidth-1:0] slot_q [NumOutputs];
    logic signed [DataWidth-1:0] best_q, cand, best_d;
    logic [IdxWidth-1:0]         best_idx_q, scan_idx_q, best_idx_d, class_q;
    logic [DataWidth-1:0]        max_q;
    logic [CountWidth-1:0]       cnt_q;
    logic                        all_full, last, hs, take;
    always_comb begin
        cap        = (state_q == COLLECT) ? bus.req_i & ~full_q : '0;
        all_full   = &full_q;
        last       = scan_idx_q == IdxWidth'(NumOutputs - 1);
        hs         = (state_q == PRESENT) && bus.ready_i;
        cand       = slot_q[scan_idx_q];
        take       = cand > best_q;
        best_d     = take ? cand : best_q;
        best_idx_d = take ? scan_idx_q : best_idx_q;
        state_d    = (state_q == COLLECT) ? (all_full ? ((NumOutputs == 1) ? PRESENT : SCAN) : COLLECT) :
                     (state_q == SCAN)    ? (last ? PRESENT : SCAN) :
                     (bus.ready_i ? COLLECT : PRESENT);
    end
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= COLLECT;
            full_q     <= '0;
            ack_q      <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            scan_idx_q <= '0;
            class_q    <= '0;
            max_q      <= '0;
            cnt_q      <= '0;
            for (int k = 0; k < NumOutputs; k++) slot_q[k] <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= cap;
            full_q  <= hs ? '0 : full_q | cap;
            for (int k = 0; k < NumOutputs; k++)
                if (cap[k]) slot_q[k] <= bus.actv_i[k*DataWidth +: DataWidth];
            if (state_q == COLLECT && all_full) begin
                best_q     <= slot_q[0];
                best_idx_q <= '0;
                scan_idx_q <= IdxWidth'(1);
                if (NumOutputs == 1) begin
                    class_q <= '0;
                    max_q   <= slot_q[0];
                end
            end
            // output registers load only on entry to PRESENT so they hold while idle
            if (state_q == SCAN) begin
                best_q     <= best_d;
                best_idx_q <= best_idx_d;
                scan_idx_q <= scan_idx_q + IdxWidth'(1);
                if (last) begin
                    class_q <= best_idx_d;
                    max_q   <= best_d;
                end
            end
            if (hs) cnt_q <= cnt_q + CountWidth'(1);
        end
    end
    assign bus.ack_o    = ack_q;
    assign bus.valid_o  = state_q == PRESENT;
    assign bus.class_o  = class_q;
    assign bus.max_o    = max_q;
    assign busy_o       = state_q != COLLECT;
    assign done_count_o = cnt_q;
endmodule

// File: tb/tb_nn_argmax_collector.sv
// tb_nn_argmax_collector: directed checks of capture, argmax, latency, backpressure, reset and counter wrap
module tb_nn_argmax_collector;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       busy;
    logic [3:0] done;
    int         nchk = 0;
    int         nerr = 0;
    int         exp_cnt = 0;
    nn_argmax_collector_if #(.DataWidth(8), .NumOutputs(4), .IdxWidth(2)) bus ();
    nn_argmax_collector #(.DataWidth(8), .NumOutputs(4), .CountWidth(4)) dut (
        .clk_i(clk), .reset_i(reset_n), .bus(bus.slave), .busy_o(busy), .done_count_o(done)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic vec4(input string tag, input logic [7:0] a0, a1, a2, a3,
                        input logic [1:0] ecls, input logic [7:0] emax);
        bus.actv_i = {a3, a2, a1, a0};
        bus.req_i  = 4'hf;
        tick();
        chk({tag, "_ack"}, bus.ack_o, 4'hf);
        bus.req_i = 4'h0;
        tick();
        chk({tag, "_ack1"}, bus.ack_o, 4'h0);
        chk({tag, "_busy"}, busy, 1'b1);
        repeat (2) tick();
        chk({tag, "_early"}, bus.valid_o, 1'b0);
        tick();
        chk({tag, "_valid"}, bus.valid_o, 1'b1);
        chk({tag, "_class"}, bus.class_o, ecls);
        chk({tag, "_max"}, bus.max_o, emax);
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        exp_cnt = (exp_cnt + 1) % 16;
        chk({tag, "_vdrop"}, bus.valid_o, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
        chk({tag, "_cnt"}, done, exp_cnt);
        chk({tag, "_hold"}, {bus.class_o, bus.max_o}, {ecls, emax});
    endtask
    initial begin
        bus.actv_i  = '0;
        bus.req_i   = '0;
        bus.ready_i = 1'b0;
        repeat (2) tick();
        chk("rst_ack", bus.ack_o, 4'h0);
        chk("rst_out", {bus.valid_o, bus.class_o, bus.max_o, busy, done}, 0);
        reset_n = 1'b1;
        tick();
        vec4("basic", 8'd10, 8'hFD, 8'd100, 8'd7, 2'd2, 8'd100);
        vec4("tie", 8'd50, 8'd50, 8'hFF, 8'd50, 2'd0, 8'd50);
        vec4("neg", 8'h80, 8'hFB, 8'hFA, 8'h80, 2'd1, 8'hFB);
        // staggered arrival; slot 3 re-requested with a larger value that must be ignored
        bus.actv_i[24 +: 8] = 8'h11;
        bus.req_i = 4'b1000;
        tick();
        chk("stg_c0", bus.ack_o, 4'b1000);
        bus.req_i = 4'b0000;
        tick();
        chk("stg_c1", bus.ack_o, 4'b0000);
        bus.actv_i[24 +: 8] = 8'h77;
        bus.req_i = 4'b1000;
        tick();
        chk("stg_c2", bus.ack_o, 4'b0000);
        bus.actv_i[0 +: 8] = 8'd5;
        bus.req_i[0] = 1'b1;
        tick();
        chk("stg_c3", bus.ack_o, 4'b0001);
        bus.req_i[0] = 1'b0;
        tick();
        chk("stg_c4", bus.ack_o, 4'b0000);
        bus.actv_i[16 +: 8] = 8'hFE;
        bus.req_i[2] = 1'b1;
        tick();
        chk("stg_c5", bus.ack_o, 4'b0100);
        bus.req_i[2] = 1'b0;
        for (int c = 6; c < 9; c++) begin
            tick();
            chk("stg_gap", {bus.ack_o, bus.valid_o}, 5'b0);
        end
        bus.actv_i[8 +: 8] = 8'h20;
        bus.req_i[1] = 1'b1;
        tick();
        chk("stg_c9", bus.ack_o, 4'b0010);
        bus.req_i[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("stg_lat", {bus.ack_o, bus.valid_o}, 5'b0);
        end
        tick();
        chk("stg_valid", bus.valid_o, 1'b1);
        chk("stg_res", {bus.class_o, bus.max_o}, {2'd1, 8'h20});
        // backpressure with every producer requesting new data
        bus.actv_i = {8'd8, 8'd9, 8'hF7, 8'd9};
        bus.req_i  = 4'hf;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("bp_hold", {bus.ack_o, bus.valid_o, bus.class_o, bus.max_o}, {4'h0, 1'b1, 2'd1, 8'h20});
        end
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        exp_cnt = (exp_cnt + 1) % 16;
        chk("bp_hs", {bus.valid_o, done}, {1'b0, 4'(exp_cnt)});
        chk("bp_noack", bus.ack_o, 4'h0);
        tick();
        chk("bp_resume", bus.ack_o, 4'hf);
        bus.req_i = 4'h0;
        repeat (3) tick();
        chk("bp_early", bus.valid_o, 1'b0);
        tick();
        chk("bp_res", {bus.valid_o, bus.class_o, bus.max_o}, {1'b1, 2'd0, 8'd9});
        bus.ready_i = 1'b1;
        tick();
        bus.ready_i = 1'b0;
        exp_cnt = (exp_cnt + 1) % 16;
        chk("bp_cnt", done, exp_cnt);
        // asynchronous reset while scanning
        bus.actv_i = {4{8'd7}};
        bus.req_i  = 4'hf;
        tick();
        bus.req_i = 4'h0;
        repeat (2) tick();
        chk("mid_busy", busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        exp_cnt = 0;
        chk("mid_rst", {bus.ack_o, bus.valid_o, bus.class_o, bus.max_o, busy, done}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        vec4("after_rst", 8'd1, 8'd2, 8'd3, 8'd4, 2'd3, 8'd4);
        chk("after_cnt", done, 4'd1);
        for (int i = 0; i < 17; i++) vec4("wrap", 8'd3, 8'hFC, 8'd9, 8'd9, 2'd2, 8'd9);
        chk("wrap_final", done, 4'd2);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/nn_argmax_collector.md
Name: nn_argmax_collector

Overview:
- Downstream stage of the output neuron layer.
- Accepts one activation per output neuron over the per-neuron req/ack handshake and buffers the full output vector.
- Runs a sequential signed argmax over the buffer.
- Presents the winning class index and its activation on a valid/ready interface toward the host/classification logic.

Parameters:
- DataWidth, 8, width of each activation (two's-complement signed).
- NumOutputs, 4, number of output-layer neurons feeding this block (>=1).
- IdxWidth, $clog2(NumOutputs) (min 1), width of class_o.
- CountWidth, 16, width of the completed-classification counter.

Ports:
- clk_i  in  1  clock; all flops rising-edge.
- reset_i  in  1  asynchronous, active-low reset.
- actv_i  in  DataWidth*NumOutputs  activation of neuron k at bits [k*DataWidth +: DataWidth].
- req_i  in  NumOutputs  per-neuron request; neuron k holds req_i[k] and its activation stable until acked.
- ack_o  out  NumOutputs  per-neuron capture acknowledge.
- valid_o  out  1  result valid.
- ready_i  in  1  consumer ready.
- class_o  out  IdxWidth  index of the maximum activation.
- max_o  out  DataWidth  value of the maximum activation.
- busy_o  out  1  high in SCAN or PRESENT.
- done_count_o  out  CountWidth  number of results accepted by the consumer.

Behaviour:
- FSM states: COLLECT (reset state), SCAN, PRESENT.
- Reset (reset_i low, async):
  - state=COLLECT; all slot-full flags=0; slot data=0.
  - ack_o=0, valid_o=0, class_o=0, max_o=0, busy_o=0, done_count_o=0.
- COLLECT:
  - For each k with req_i[k]=1 and slot k empty: registered ack_o[k]=1 for exactly one cycle; actv_i slice k captured on the same edge; slot k marked full.
  - Multiple slots may be captured on the same edge; arrival order is irrelevant.
  - req_i[k] while slot k is full: no ack; request stays pending.
  - When all slots are full (registered flags), next edge -> SCAN: best=slot0, best_idx=0, scan_idx=1.
- SCAN:
  - One compare per cycle, signed: if slot[scan_idx] > best, then best=slot[scan_idx] and best_idx=scan_idx.
  - Strictly greater, so ties keep the lowest index.
  - After comparing index NumOutputs-1 -> PRESENT.
  - NumOutputs=1: SCAN is transitional only; COLLECT goes straight to PRESENT with slot0.
- Latency: valid_o rises exactly NumOutputs clock edges after the edge that captured the last slot.
- PRESENT:
  - valid_o=1; class_o/max_o stable until handshake.
  - valid_o & ready_i on an edge: clear all slot-full flags; done_count_o+=1 (wraps modulo 2^CountWidth); valid_o=0; -> COLLECT.
  - ready_i already high on the first PRESENT cycle: handshake completes on that edge.
- req_i is ignored in SCAN and PRESENT (no ack, no capture). Producers stall.
- First ack for a new vector is possible on the first COLLECT cycle after the handshake.
- class_o/max_o hold their last values while valid_o=0.
- busy_o = (state != COLLECT).
- Reset asserted mid-SCAN or mid-PRESENT: all partial data discarded; no result emitted; done_count_o=0.

Test Plan:
- Basic argmax (N=4, DW=8): all req_i=4'b1111 with values {10,-3,100,7} -> ack_o=4'b1111 for 1 cycle; valid_o 4 edges later; class_o=2, max_o=8'd100; ready_i=1 -> done_count_o=1, back to COLLECT.
- Tie and negatives:
  - {50,50,-1,50} -> class_o=0, max_o=50.
  - {-128,-5,-6,-128} -> class_o=1, max_o=8'hFB.
  - Signed compare, lowest-index tie rule.
- Staggered arrival with repeat request: req_i[3] at cycle 0, [0] at 3, [2] at 5, [1] at 9; req_i[3] re-raised at cycle 2 with new data -> each slot acked once; the re-raised slot-3 request gets no ack; result uses the first slot-3 value; valid_o 4 edges after the cycle-9 capture.
- Backpressure: ready_i=0 for 20 cycles in PRESENT while producers raise new reqs -> valid_o/class_o/max_o stable, ack_o=0 throughout; ready_i=1 -> handshake; acks resume next cycle.
- Reset mid-operation: assert reset_i low during SCAN -> all outputs zero immediately (async); after release, a full new vector {1,2,3,4} -> class_o=3, max_o=4, done_count_o=1.
- Counter wrap (CountWidth=4): 17 back-to-back vectors -> done_count_o sequence wraps 15 -> 0 -> 1.
